// File: rtl/tpu_acc_pkg.sv
// ----------------------------------------------------------------------------
// tpu_acc_pkg
// Shared types and sizing constants for the accumulator bank and its helpers.
//   acc_clr_state_t : sequential clear FSM states
//   ACC_LANE_W      : default width of one signed partial-sum lane
//   ACC_DEPTH       : default number of two-lane entries
//   acc_entry_t     : one stored entry, {hi, lo}
// ----------------------------------------------------------------------------
package tpu_acc_pkg;

    localparam int ACC_LANE_W = 32;
    localparam int ACC_DEPTH  = 256;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CLEARING = 2'd1,
        COMPLETE = 2'd2
    } acc_clr_state_t;

    typedef struct packed {
        logic [ACC_LANE_W-1:0] hi;
        logic [ACC_LANE_W-1:0] lo;
    } acc_entry_t;

endpackage

// File: rtl/acc_lane_adder.sv
// ----------------------------------------------------------------------------
// acc_lane_adder
// Signed two's-complement adder for one accumulator lane, with optional
// clamping to the signed range.
//   a, b  in   LANE_W  signed operands (stored value, incoming value)
//   sum   out  LANE_W  wrapped sum, or clamped sum when SATURATE=1
//   sat   out  1       overflow was clamped (always 0 when SATURATE=0)
// ----------------------------------------------------------------------------
module acc_lane_adder
    import tpu_acc_pkg::*;
#(
    parameter int LANE_W   = ACC_LANE_W,
    parameter bit SATURATE = 1'b0
) (
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] b,
    output logic [LANE_W-1:0] sum,
    output logic              sat
);

    localparam logic [LANE_W-1:0] MAX_VAL = {1'b0, {(LANE_W-1){1'b1}}};
    localparam logic [LANE_W-1:0] MIN_VAL = {1'b1, {(LANE_W-1){1'b0}}};

    logic [LANE_W:0] full;
    logic            overflow;

    // Add with one extra sign bit; overflow shows up as the top two bits of
    // the extended sum disagreeing, and the top bit is the true sign.
    always_comb begin
        full     = {a[LANE_W-1], a} + {b[LANE_W-1], b};
        overflow = full[LANE_W] ^ full[LANE_W-1];
        sum      = full[LANE_W-1:0];
        sat      = 1'b0;
        if (SATURATE && overflow) begin
            sum = full[LANE_W] ? MIN_VAL : MAX_VAL;
            sat = 1'b1;
        end
    end

endmodule

// File: rtl/accumulator_bank.sv
// ----------------------------------------------------------------------------
// accumulator_bank
// Result store behind the systolic controller: DEPTH entries of two signed
// LANE_W partial sums, supporting column overwrite/accumulate writes, a
// DEPTH-cycle sequential clear, and a 1-cycle-latency read port.
//   clk, rst                      clock, synchronous active-high reset
//   acc_in0/1/2                   column results from the array bottom row
//   acc_wr_en, acc_wr_addr        write strobe and entry address
//   acc_wr_col01 / acc_wr_col2    select {in1,in0} or {0,in2} (exactly one)
//   acc_accumulate                1 = add to stored value, 0 = overwrite
//   acc_clear                     level clear request (needs 0->1 to re-arm)
//   acc_clear_busy/_complete      clear in progress / one-cycle done pulse
//   rd_en, rd_addr                read request
//   rd_data, rd_valid             registered {hi, lo} read result
//   wr_dropped, sat_hit           sticky: write lost to a clear / clamp seen
// ----------------------------------------------------------------------------
module accumulator_bank
    import tpu_acc_pkg::*;
#(
    parameter int DEPTH    = ACC_DEPTH,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int LANE_W   = ACC_LANE_W,
    parameter bit SATURATE = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LANE_W-1:0]     acc_in0,
    input  logic [LANE_W-1:0]     acc_in1,
    input  logic [LANE_W-1:0]     acc_in2,
    input  logic                  acc_wr_en,
    input  logic [ADDR_W-1:0]     acc_wr_addr,
    input  logic                  acc_wr_col01,
    input  logic                  acc_wr_col2,
    input  logic                  acc_accumulate,
    input  logic                  acc_clear,
    output logic                  acc_clear_busy,
    output logic                  acc_clear_complete,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [2*LANE_W-1:0]   rd_data,
    output logic                  rd_valid,
    output logic                  wr_dropped,
    output logic                  sat_hit
);

    localparam int                ENTRY_W  = 2 * LANE_W;
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    logic [ENTRY_W-1:0] mem [DEPTH];

    acc_clr_state_t     state;
    logic [ADDR_W-1:0]  clr_ptr;
    logic               armed;

    logic               wr_valid;
    logic               wr_allowed;
    logic [LANE_W-1:0]  new_lo;
    logic [LANE_W-1:0]  new_hi;
    logic [ENTRY_W-1:0] old_entry;
    logic [LANE_W-1:0]  sum_lo;
    logic [LANE_W-1:0]  sum_hi;
    logic               sat_lo;
    logic               sat_hi;
    logic [LANE_W-1:0]  wr_lo;
    logic [LANE_W-1:0]  wr_hi;
    logic               wr_sat;

    // A write needs exactly one column select; it only lands while IDLE, so
    // the clear owns the array for the whole CLEARING/COMPLETE window.
    assign wr_valid   = acc_wr_en & (acc_wr_col01 ^ acc_wr_col2);
    assign wr_allowed = wr_valid & (state == IDLE);

    assign new_lo    = acc_wr_col01 ? acc_in0 : acc_in2;
    assign new_hi    = acc_wr_col01 ? acc_in1 : '0;
    assign old_entry = mem[acc_wr_addr];

    acc_lane_adder #(.LANE_W(LANE_W), .SATURATE(SATURATE)) u_add_lo (
        .a   (old_entry[LANE_W-1:0]),
        .b   (new_lo),
        .sum (sum_lo),
        .sat (sat_lo)
    );

    acc_lane_adder #(.LANE_W(LANE_W), .SATURATE(SATURATE)) u_add_hi (
        .a   (old_entry[ENTRY_W-1:LANE_W]),
        .b   (new_hi),
        .sum (sum_hi),
        .sat (sat_hi)
    );

    assign wr_lo  = acc_accumulate ? sum_lo : new_lo;
    assign wr_hi  = acc_accumulate ? sum_hi : new_hi;
    assign wr_sat = acc_accumulate & (sat_lo | sat_hi);

    // Clear FSM. 'armed' recovers in any cycle the request is low, so a level
    // held high through COMPLETE cannot start a second clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            clr_ptr <= '0;
            armed   <= 1'b1;
        end else begin
            if (!acc_clear) begin
                armed <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (acc_clear && armed) begin
                        state   <= CLEARING;
                        clr_ptr <= '0;
                        armed   <= 1'b0;
                    end
                end
                CLEARING: begin
                    clr_ptr <= clr_ptr + ADDR_W'(1);
                    if (clr_ptr == LAST_PTR) begin
                        state <= COMPLETE;
                    end
                end
                COMPLETE: state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

    assign acc_clear_busy     = (state == CLEARING);
    assign acc_clear_complete = (state == COMPLETE);

    // Storage has no reset; the array is zeroed only by the sequential clear.
    // Nothing is written while rst is high so a reset mid-clear leaves the
    // partially cleared contents exactly as they were.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEARING) begin
                mem[clr_ptr] <= '0;
            end else if (wr_allowed) begin
                mem[acc_wr_addr] <= {wr_hi, wr_lo};
            end
        end
    end

    // Read port samples the array before this edge's write, giving
    // read-before-write on a same-address collision. Flags are sticky.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            wr_dropped <= 1'b0;
            sat_hit    <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= mem[rd_addr];
            end
            if (wr_valid && (state != IDLE)) begin
                wr_dropped <= 1'b1;
            end
            if (wr_allowed && wr_sat) begin
                sat_hit <= 1'b1;
            end
        end
    end

endmodule
